// File: rtl/bus_timer_pkg.sv
// rtl/bus_timer_pkg.sv - register offsets and bit positions for bus_timer
//
// Purpose: register map shared by the RTL and the testbench.
// Contents: tmr_addr_e register offsets, CTRL and STAT bit indices.

package bus_timer_pkg;

  typedef enum logic [2:0] {
    TMR_CTRL  = 3'd0,
    TMR_STAT  = 3'd1,
    TMR_LDLO  = 3'd2,
    TMR_LDHI  = 3'd3,
    TMR_CNTLO = 3'd4,
    TMR_CNTHI = 3'd5,
    TMR_PRE   = 3'd6,
    TMR_RSVD  = 3'd7
  } tmr_addr_e;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;

  localparam int STAT_TF   = 0;
  localparam int STAT_RUN  = 7;

endpackage

// File: rtl/bus_timer_prescale.sv
// rtl/bus_timer_prescale.sv - 8-bit prescaler producing the timer tick
//
// Purpose: counts clocks while enabled and issues a one-cycle tick when the
//   count equals the compare value, wrapping back to zero on that tick.
// Ports:
//   clk     in  clock
//   rstn_i  in  synchronous active-low reset
//   en_i    in  count enable
//   clr_i   in  force counter to zero (dominates)
//   cmp_i   in  compare value (divide by cmp_i+1)
//   tick_o  out one-cycle tick, combinational from the current count

module timer_prescale (
  input  logic       clk,
  input  logic       rstn_i,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [7:0] cmp_i,
  output logic       tick_o
);

  logic [7:0] pre_q, pre_d;

  assign tick_o = en_i && (pre_q == cmp_i);

  // A compare value lowered below the running count lets the counter run
  // on to 8'hFF and wrap naturally before matching again.
  always_comb begin
    pre_d = pre_q;
    if (clr_i)       pre_d = 8'h00;
    else if (tick_o) pre_d = 8'h00;
    else if (en_i)   pre_d = pre_q + 8'h01;
  end

  always_ff @(posedge clk) begin
    if (!rstn_i) pre_q <= 8'h00;
    else         pre_q <= pre_d;
  end

endmodule

// File: rtl/bus_timer.sv
// rtl/bus_timer.sv - 16-bit programmable interval timer on the CPU bus
//
// Purpose: bus responder with CTRL/STAT/LOAD/CNT/PRESCALE registers, a
//   down-counter driven by a prescaler tick, one-shot or auto-reload mode,
//   a coherent LO-then-HI count snapshot and a registered interrupt request.
// Ports:
//   clk    in  CPU clock
//   reset  in  synchronous active-low reset
//   cs     in  chip select
//   we     in  write enable, qualified by cs
//   addr   in  register select
//   din    in  write data
//   dout   out registered read data
//   irq    out registered interrupt request (TF & IE)

module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [15:0] RST_LOAD     = 16'hFFFF,
  parameter logic [7:0]  RST_PRESCALE = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq
);

  logic [2:0]  ctrl_q, ctrl_d;
  logic        tf_q, tf_d;
  logic        run_q, run_d;
  logic [15:0] load_q, load_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  pscale_q, pscale_d;
  logic [7:0]  snap_q, snap_d;
  logic [7:0]  dout_q, dout_d;
  logic        irq_q, irq_d;

  logic        tick;
  logic        wr, rd, ldhi_wr, expire;
  tmr_addr_e   reg_sel;

  assign reg_sel = tmr_addr_e'(addr);
  assign wr      = cs && we;
  assign rd      = cs && !we;
  assign ldhi_wr = wr && (reg_sel == TMR_LDHI);
  // A LOAD_HI write on the same edge as the final tick suppresses expiry.
  assign expire  = tick && (cnt_q == 16'h0000) && !ldhi_wr;

  timer_prescale u_prescale (
    .clk    (clk),
    .rstn_i (reset),
    .en_i   (ctrl_q[CTRL_EN] && run_q),
    .clr_i  (ldhi_wr),
    .cmp_i  (pscale_q),
    .tick_o (tick)
  );

  always_comb begin
    ctrl_d   = ctrl_q;
    load_d   = load_q;
    pscale_d = pscale_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    snap_d   = snap_q;
    dout_d   = dout_q;
    irq_d    = tf_q && ctrl_q[CTRL_IE];

    // Expiry sets TF even when a write-1-to-clear lands on the same edge.
    tf_d = expire || (tf_q && !(wr && (reg_sel == TMR_STAT) && din[STAT_TF]));

    if (tick && (cnt_q != 16'h0000)) begin
      cnt_d = cnt_q - 16'h0001;
    end else if (expire) begin
      if (ctrl_q[CTRL_AUTO]) cnt_d = load_q;
      else                   run_d = 1'b0;
    end

    if (wr) begin
      case (reg_sel)
        TMR_CTRL: ctrl_d = din[2:0];
        TMR_LDLO: load_d[7:0] = din;
        TMR_LDHI: begin
          load_d[15:8] = din;
          cnt_d        = {din, load_q[7:0]};
          run_d        = 1'b1;
        end
        TMR_PRE:  pscale_d = din;
        default:  ;
      endcase
    end

    if (rd) begin
      case (reg_sel)
        TMR_CTRL:  dout_d = {5'b0, ctrl_q};
        TMR_STAT:  dout_d = {run_q, 6'b0, tf_q};
        TMR_LDLO:  dout_d = load_q[7:0];
        TMR_LDHI:  dout_d = load_q[15:8];
        TMR_CNTLO: begin
          dout_d = cnt_q[7:0];
          snap_d = cnt_q[15:8];
        end
        TMR_CNTHI: dout_d = snap_q;
        TMR_PRE:   dout_d = pscale_q;
        default:   dout_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q   <= 3'b000;
      tf_q     <= 1'b0;
      run_q    <= 1'b0;
      load_q   <= RST_LOAD;
      cnt_q    <= RST_LOAD;
      pscale_q <= RST_PRESCALE;
      snap_q   <= 8'h00;
      dout_q   <= 8'h00;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      tf_q     <= tf_d;
      run_q    <= run_d;
      load_q   <= load_d;
      cnt_q    <= cnt_d;
      pscale_q <= pscale_d;
      snap_q   <= snap_d;
      dout_q   <= dout_d;
      irq_q    <= irq_d;
    end
  end

  assign dout = dout_q;
  assign irq  = irq_q;

endmodule

// File: tb/tb_bus_timer.sv
// tb/tb_bus_timer.sv - self-checking bench for bus_timer

module tb_bus_timer;
  import bus_timer_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cs = 1'b0;
  logic       we = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       irq;

  always #5 clk = ~clk;

  bus_timer dut (
    .clk   (clk),
    .reset (reset),
    .cs    (cs),
    .we    (we),
    .addr  (addr),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [2:0]  m_ctrl;
  logic        m_tf, m_run, m_irq;
  logic [15:0] m_load, m_cnt;
  logic [7:0]  m_pscale, m_pcnt, m_snap, m_dout;

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %02h want %02h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return {5'b0, m_ctrl};
      3'd1:    return {m_run, 6'b0, m_tf};
      3'd2:    return m_load[7:0];
      3'd3:    return m_load[15:8];
      3'd4:    return m_cnt[7:0];
      3'd5:    return m_snap;
      3'd6:    return m_pscale;
      default: return 8'h00;
    endcase
  endfunction

  // One clock edge of the timer as described in words: all decisions use the
  // state before the edge, then the bus write overrides what it touches.
  task automatic model_edge(input logic r, input logic c, input logic w,
                            input logic [2:0] a, input logic [7:0] d);
    logic        ticking, new_tf, new_run;
    logic [15:0] new_cnt, new_load;
    logic [7:0]  new_pcnt;
    if (!r) begin
      m_ctrl = 0; m_tf = 0; m_run = 0; m_load = 16'hFFFF; m_cnt = 16'hFFFF;
      m_pscale = 0; m_pcnt = 0; m_snap = 0; m_dout = 0; m_irq = 0;
      return;
    end
    ticking  = m_ctrl[0] && m_run && (m_pcnt == m_pscale);
    new_pcnt = m_pcnt;
    if (m_ctrl[0] && m_run) new_pcnt = ticking ? 8'd0 : m_pcnt + 8'd1;
    new_cnt = m_cnt; new_run = m_run; new_tf = m_tf; new_load = m_load;
    if (ticking) begin
      if (m_cnt != 0) new_cnt = m_cnt - 1;
      else begin
        new_tf = 1;
        if (m_ctrl[1]) new_cnt = m_load; else new_run = 0;
      end
    end
    m_irq = m_tf && m_ctrl[2];
    if (c && !w) begin
      m_dout = m_read(a);
      if (a == 3'd4) m_snap = m_cnt[15:8];
    end
    if (c && w) begin
      if (a == 3'd0) m_ctrl = d[2:0];
      if (a == 3'd1 && d[0] && !(ticking && m_cnt == 0)) new_tf = 0;
      if (a == 3'd2) new_load[7:0] = d;
      if (a == 3'd3) begin
        new_load[15:8] = d;
        new_cnt  = {d, m_load[7:0]};
        new_pcnt = 0;
        new_run  = 1;
        new_tf   = m_tf;
        if (a == 3'd1 && d[0]) new_tf = 0;
      end
      if (a == 3'd6) m_pscale = d;
    end
    m_tf = new_tf; m_run = new_run; m_cnt = new_cnt; m_load = new_load; m_pcnt = new_pcnt;
  endtask

  // Called at a falling edge: drive, clock, update the model, compare at the next fall.
  task automatic step(input logic r, input logic c, input logic w,
                      input logic [2:0] a, input logic [7:0] d);
    reset = r; cs = c; we = w; addr = a; din = d;
    @(posedge clk);
    model_edge(r, c, w, a, d);
    @(negedge clk);
    check8("dout_vs_model", dout, m_dout);
    check8("irq_vs_model", {7'b0, irq}, {7'b0, m_irq});
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    step(1'b1, 1'b1, 1'b1, a, d);
  endtask
  task automatic rd(input logic [2:0] a);
    step(1'b1, 1'b1, 1'b0, a, 8'h00);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
  endtask
  task automatic rst(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  initial begin
    @(negedge clk);
    // Reset values
    rst(3);
    check8("reset_dout", dout, 8'h00);
    check8("reset_irq", {7'b0, irq}, 8'h00);
    rd(TMR_LDLO);  check8("reset_load_lo", dout, 8'hFF);
    rd(TMR_LDHI);  check8("reset_load_hi", dout, 8'hFF);
    rd(TMR_PRE);   check8("reset_prescale", dout, 8'h00);

    // One-shot, LOAD=3, PRESCALE=0: TF on 4th tick, irq one clock later
    wr(TMR_PRE, 8'h00); wr(TMR_CTRL, 8'h05); wr(TMR_LDLO, 8'h03); wr(TMR_LDHI, 8'h00);
    idle(4);
    check8("oneshot_irq_not_yet", {7'b0, irq}, 8'h00);
    rd(TMR_STAT);  check8("oneshot_stat", dout, 8'h01);
    check8("oneshot_irq", {7'b0, irq}, 8'h01);
    rd(TMR_CNTLO); check8("oneshot_cnt_zero", dout, 8'h00);
    wr(TMR_CTRL, 8'h00); wr(TMR_STAT, 8'h01);

    // Periodic, PRESCALE=2, LOAD=4: expiry every 15 clocks
    wr(TMR_PRE, 8'h02); wr(TMR_LDLO, 8'h04); wr(TMR_CTRL, 8'h07); wr(TMR_LDHI, 8'h00);
    idle(14);
    rd(TMR_STAT);  check8("periodic_before_exp", dout, 8'h80);
    rd(TMR_STAT);  check8("periodic_after_exp", dout, 8'h81);
    wr(TMR_STAT, 8'h01);
    rd(TMR_STAT);  check8("periodic_w1c", dout, 8'h80);
    idle(11);
    wr(TMR_STAT, 8'h01);
    rd(TMR_STAT);  check8("periodic_set_wins", dout, 8'h81);
    wr(TMR_CTRL, 8'h00); wr(TMR_STAT, 8'h01);

    // Snapshot coherence, LOAD=1234
    wr(TMR_PRE, 8'h00); wr(TMR_CTRL, 8'h01); wr(TMR_LDLO, 8'h34); wr(TMR_LDHI, 8'h12);
    idle(52);
    rd(TMR_CNTLO); check8("snap_cnt_lo", dout, 8'h00);
    idle(4);
    rd(TMR_CNTHI); check8("snap_cnt_hi", dout, 8'h12);
    rd(TMR_CNTLO); check8("snap_cnt_lo_later", dout, 8'hFA);

    // LOAD_HI write on the expiry edge wins
    wr(TMR_LDLO, 8'h02); wr(TMR_LDHI, 8'h00);
    idle(2);
    wr(TMR_LDHI, 8'h00);
    rd(TMR_STAT);  check8("collide_no_tf", dout, 8'h80);
    rd(TMR_CNTLO); check8("collide_reload", dout, 8'h01);

    // EN=0 freezes the count
    wr(TMR_LDLO, 8'h50); wr(TMR_LDHI, 8'h00); wr(TMR_CTRL, 8'h00);
    idle(10);
    rd(TMR_CNTLO); check8("frozen_cnt", dout, 8'h4F);
    rd(TMR_RSVD);  check8("reserved_read", dout, 8'h00);

    // Degenerate LOAD=0, PRESCALE=0: TF sets every edge
    wr(TMR_STAT, 8'h01); wr(TMR_CTRL, 8'h07); wr(TMR_LDLO, 8'h00); wr(TMR_LDHI, 8'h00);
    idle(3);
    wr(TMR_STAT, 8'h01);
    rd(TMR_STAT);  check8("degenerate_tf", dout, 8'h81);
    idle(2);

    // Reset in the middle of a count
    wr(TMR_PRE, 8'h05); wr(TMR_LDLO, 8'h40); wr(TMR_LDHI, 8'h10);
    idle(3);
    rst(1);
    check8("midreset_irq", {7'b0, irq}, 8'h00);
    rd(TMR_CTRL);  check8("midreset_ctrl", dout, 8'h00);
    rd(TMR_STAT);  check8("midreset_stat", dout, 8'h00);
    rd(TMR_LDLO);  check8("midreset_load_lo", dout, 8'hFF);
    rd(TMR_CNTLO); check8("midreset_cnt_lo", dout, 8'hFF);
    rd(TMR_PRE);   check8("midreset_prescale", dout, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
